// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation sequencer.
`default_nettype none

package rsa_pkg;

    localparam int WIDTH  = 256;
    localparam int MM_LAT = 132;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE_M   = 3'd1,
        ST_PRE_ACC = 3'd2,
        ST_SQR     = 3'd3,
        ST_MUL     = 3'd4,
        ST_POST    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rsa_modexp_ctrl.sv
// MSB-first square-and-multiply sequencer driving the Montgomery multiplier,
// one multiplication at a time over its beg/out_ready handshake.
`default_nettype none

module rsa_modexp_ctrl
    import rsa_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] msg,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modn,
    input  logic [WIDTH-1:0] r2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_n,
    output logic             mm_beg,
    input  logic [WIDTH-1:0] mm_out,
    input  logic             mm_out_ready
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic             wait_q, wait_d;
    logic [7:0]       bit_q, bit_d;
    logic [WIDTH-1:0] msg_q, exp_q, modn_q, r2_q;
    logic [WIDTH-1:0] mbar_q, acc_q, result_q;

    logic accept;
    logic op_done;

    assign accept  = (state_q == ST_IDLE) && start;
    // mm_out is only trusted while the multiplier is running (WAIT phase).
    assign op_done = wait_q && !mm_out_ready;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        bit_d   = bit_q;
        case (state_q)
            ST_IDLE: begin
                wait_d = 1'b0;
                if (start) begin
                    state_d = ST_PRE_M;
                    bit_d   = 8'hFF;
                end
            end
            ST_PRE_M, ST_PRE_ACC, ST_SQR, ST_MUL, ST_POST: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (!mm_out_ready) begin
                    wait_d = 1'b0;
                    case (state_q)
                        ST_PRE_M:   state_d = ST_PRE_ACC;
                        ST_PRE_ACC: state_d = ST_SQR;
                        ST_SQR: begin
                            if (exp_q[bit_q]) begin
                                state_d = ST_MUL;
                            end else begin
                                state_d = (bit_q == 8'd0) ? ST_POST : ST_SQR;
                                bit_d   = bit_q - 8'd1;
                            end
                        end
                        ST_MUL: begin
                            state_d = (bit_q == 8'd0) ? ST_POST : ST_SQR;
                            bit_d   = bit_q - 8'd1;
                        end
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                wait_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                wait_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= 1'b0;
            bit_q    <= 8'd0;
            msg_q    <= '0;
            exp_q    <= '0;
            modn_q   <= '0;
            r2_q     <= '0;
            mbar_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            bit_q   <= bit_d;
            if (accept) begin
                msg_q  <= msg;
                exp_q  <= exp;
                modn_q <= modn;
                r2_q   <= r2;
            end
            if (op_done) begin
                case (state_q)
                    ST_PRE_M: mbar_q <= mm_out;
                    ST_POST: begin
                        acc_q    <= mm_out;
                        result_q <= mm_out;
                    end
                    default: acc_q <= mm_out;
                endcase
            end
        end
    end

    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state_q)
            ST_PRE_M: begin
                mm_a = msg_q;
                mm_b = r2_q;
            end
            ST_PRE_ACC: begin
                mm_a = ONE;
                mm_b = r2_q;
            end
            ST_SQR: begin
                mm_a = acc_q;
                mm_b = acc_q;
            end
            ST_MUL: begin
                mm_a = acc_q;
                mm_b = mbar_q;
            end
            ST_POST: begin
                mm_a = acc_q;
                mm_b = ONE;
            end
            default: begin
                mm_a = '0;
                mm_b = '0;
            end
        endcase
    end

    assign mm_n   = modn_q;
    assign mm_beg = wait_q;
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: behavioural Montgomery multiplier plus a
// plain-arithmetic modexp reference.
`default_nettype none

module tb_rsa_modexp_ctrl;
    import rsa_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] msg = '0, exp = '0, modn = '0, r2 = '0;
    logic             busy, done, mm_beg;
    logic [WIDTH-1:0] result, mm_a, mm_b, mm_n;
    logic [WIDTH-1:0] mm_out;
    logic             mm_out_ready;

    int total = 0;
    int bad   = 0;

    rsa_modexp_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .msg          (msg),
        .exp          (exp),
        .modn         (modn),
        .r2           (r2),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .mm_a         (mm_a),
        .mm_b         (mm_b),
        .mm_n         (mm_n),
        .mm_beg       (mm_beg),
        .mm_out       (mm_out),
        .mm_out_ready (mm_out_ready)
    );

    always #5 clk = ~clk;

    // MM(a,b) = a*b*2^-256 mod n, by halving modulo n 256 times.
    function automatic logic [WIDTH-1:0] mont(input logic [WIDTH-1:0] a, b, n);
        logic [511:0] t;
        t = ({256'd0, a} * {256'd0, b}) % {256'd0, n};
        for (int i = 0; i < 256; i++) begin
            if (t[0]) t = t + {256'd0, n};
            t = t >> 1;
        end
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] m, e, n);
        logic [511:0] r, mm, nn;
        nn = {256'd0, n};
        mm = {256'd0, m} % nn;
        r  = 512'd1 % nn;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            r = (r * r) % nn;
            if (e[i]) r = (r * mm) % nn;
        end
        return r[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] calc_r2(input logic [WIDTH-1:0] n);
        logic [511:0] t, nn;
        nn = {256'd0, n};
        t  = (512'd1 << 256) % nn;
        t  = (t * t) % nn;
        return t[WIDTH-1:0];
    endfunction

    function automatic int popcount(input logic [WIDTH-1:0] v);
        int c = 0;
        for (int i = 0; i < WIDTH; i++) c += int'(v[i]);
        return c;
    endfunction

    // Multiplier model: ready drops lat cycles after beg rises and stays low
    // until the next LOAD edge, so a stale low is visible during LOAD.
    int           lat = MM_LAT - 2;
    int           cnt = 0;
    int           op_cnt = 0;
    int           stab_err = 0;
    logic [WIDTH-1:0] prod = '0, ha = '0, hb = '0, hn = '0;

    assign mm_out       = prod;
    assign mm_out_ready = !(cnt == lat);

    always @(posedge clk) begin
        if (!mm_beg) begin
            cnt <= 0;
        end else begin
            if (cnt == 0) begin
                prod   <= mont(mm_a, mm_b, mm_n);
                ha     <= mm_a;
                hb     <= mm_b;
                hn     <= mm_n;
                op_cnt <= op_cnt + 1;
            end else if (mm_a !== ha || mm_b !== hb || mm_n !== hn) begin
                stab_err <= stab_err + 1;
            end
            if (cnt < lat) cnt <= cnt + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_job(input logic [WIDTH-1:0] m, e, n, rr,
                           output logic [WIDTH-1:0] res, output int bcyc,
                           output int ops, output bit tmo);
        int k = 0;
        int ops0;
        ops0  = op_cnt;
        bcyc  = 0;
        tmo   = 1'b0;
        msg   = m;
        exp   = e;
        modn  = n;
        r2    = rr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && k < 60000) begin
            if (busy) bcyc++;
            @(negedge clk);
            k++;
        end
        res = result;
        ops = op_cnt - ops0;
        if (!done) begin
            tmo = 1'b1;
            total++;
            bad++;
            $display("FAIL job_timeout: done not seen after %0d cycles", k);
            do_reset();
        end else begin
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_at_done: got %b want 0", busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 7;
        if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (done !== 1'b0)   begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        if (mm_beg !== 1'b0) begin bad++; $display("FAIL rst_beg: got %b want 0", mm_beg); end
        if (result !== '0)   begin bad++; $display("FAIL rst_result: got %h want 0", result); end
        if (mm_a !== '0)     begin bad++; $display("FAIL rst_mm_a: got %h want 0", mm_a); end
        if (mm_b !== '0)     begin bad++; $display("FAIL rst_mm_b: got %h want 0", mm_b); end
        if (mm_n !== '0)     begin bad++; $display("FAIL rst_mm_n: got %h want 0", mm_n); end
    endtask

    task automatic test_full_latency();
        logic [WIDTH-1:0] res;
        int bcyc, ops, s0, want_c;
        bit tmo;
        lat = MM_LAT - 2;
        s0  = stab_err;
        run_job(256'd4, 256'd3, 256'd13, 256'd9, res, bcyc, ops, tmo);
        if (!tmo) begin
            want_c = MM_LAT * (259 + popcount(256'd3));
            total += 4;
            if (res !== modexp(256'd4, 256'd3, 256'd13)) begin
                bad++; $display("FAIL full_result: got %0d want %0d", res, modexp(256'd4, 256'd3, 256'd13));
            end
            if (res !== 256'd12) begin bad++; $display("FAIL full_result_12: got %0d want 12", res); end
            if (bcyc != want_c) begin bad++; $display("FAIL full_busy_cycles: got %0d want %0d", bcyc, want_c); end
            if (stab_err != s0) begin bad++; $display("FAIL full_stable: got %0d changes want 0", stab_err - s0); end
        end
    endtask

    task automatic test_small_fast();
        logic [WIDTH-1:0] res;
        int bcyc, ops;
        bit tmo;
        lat = 1;
        run_job(256'd2, 256'd12, 256'd13, 256'd9, res, bcyc, ops, tmo);
        if (!tmo) begin
            total += 2;
            if (res !== 256'd1) begin bad++; $display("FAIL e12_result: got %0d want 1", res); end
            if (ops != 259 + 2) begin bad++; $display("FAIL e12_ops: got %0d want 261", ops); end
        end
        run_job(256'd7, 256'd0, 256'd13, 256'd9, res, bcyc, ops, tmo);
        if (!tmo) begin
            total += 3;
            if (res !== 256'd1) begin bad++; $display("FAIL e0_result: got %0d want 1", res); end
            if (ops != 259) begin bad++; $display("FAIL e0_ops: got %0d want 259", ops); end
            if (bcyc != (lat + 2) * 259) begin
                bad++; $display("FAIL e0_busy_cycles: got %0d want %0d", bcyc, (lat + 2) * 259);
            end
        end
    endtask

    task automatic test_start_ignored();
        int k = 0;
        lat   = 1;
        msg   = 256'd4;
        exp   = 256'd3;
        modn  = 256'd13;
        r2    = 256'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        msg   = 256'd5;
        exp   = 256'd7;
        modn  = 256'd17;
        r2    = calc_r2(256'd17);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!done && k < 60000) begin
            @(negedge clk);
            k++;
        end
        // A start during the DONE cycle must also be dropped.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total += 2;
        if (result !== 256'd12) begin bad++; $display("FAIL ignore_start_result: got %0d want 12", result); end
        if (busy !== 1'b0) begin bad++; $display("FAIL start_in_done: busy got %b want 0", busy); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] res, want;
        int bcyc, ops, k, dseen;
        bit tmo;
        lat   = 10;
        k     = 0;
        dseen = 0;
        msg   = 256'd4;
        exp   = 256'd3;
        modn  = 256'd13;
        r2    = 256'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        while (!mm_beg && k < 100) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (mm_beg !== 1'b1) begin bad++; $display("FAIL rmid_in_wait: got %b want 1", mm_beg); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total += 2;
        if (mm_beg !== 1'b0) begin bad++; $display("FAIL rmid_beg: got %b want 0", mm_beg); end
        if (busy !== 1'b0)   begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
        repeat (50) begin
            if (done) dseen++;
            @(negedge clk);
        end
        total++;
        if (dseen != 0) begin bad++; $display("FAIL rmid_no_done: got %0d pulses want 0", dseen); end
        want = modexp(256'd3, 256'd5, 256'd13);
        run_job(256'd3, 256'd5, 256'd13, 256'd9, res, bcyc, ops, tmo);
        if (!tmo) begin
            total++;
            if (res !== want) begin bad++; $display("FAIL rmid_after: got %0d want %0d", res, want); end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] n, m, e, rr, res, want;
        int bcyc, ops, s0;
        bit tmo;
        lat = 1;
        for (int j = 0; j < 20; j++) begin
            for (int w = 0; w < 8; w++) begin
                n[w*32 +: 32] = $urandom;
                m[w*32 +: 32] = $urandom;
                e[w*32 +: 32] = $urandom;
            end
            n[255]   = 1'b1;
            n[1:0]   = 2'b01;
            m        = m % n;
            rr       = calc_r2(n);
            want     = modexp(m, e, n);
            s0       = stab_err;
            run_job(m, e, n, rr, res, bcyc, ops, tmo);
            if (!tmo) begin
                total += 3;
                if (res !== want) begin bad++; $display("FAIL rand_result[%0d]: got %h want %h", j, res, want); end
                if (ops != 259 + popcount(e)) begin
                    bad++; $display("FAIL rand_ops[%0d]: got %0d want %0d", j, ops, 259 + popcount(e));
                end
                if (stab_err != s0) begin bad++; $display("FAIL rand_stable[%0d]: got %0d changes want 0", j, stab_err - s0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_latency();
        test_small_fast();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
